// File: rtl/bcd_tick_counter.sv
// Multi-digit BCD up/down counter stepped by an internal prescaler tick.
// Also provides a registered tick pulse, a wrap pulse and a blink square wave.
module bcd_tick_counter #(
  parameter int CLK_HZ  = 16_000_000,
  parameter int TICK_HZ = 2,
  parameter int DIGITS  = 2,
  parameter int STEP    = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_up,
  input  logic                  i_clr,
  input  logic                  i_load,
  input  logic [4*DIGITS-1:0]   i_load_val,
  output logic [4*DIGITS-1:0]   o_bcd_out,
  output logic                  o_tick,
  output logic                  o_wrap,
  output logic                  o_blink
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  if (DIV < 2 || DIGITS < 1 || DIGITS > 8 || STEP < 1 || STEP > 9) begin : g_bad_param
    $error("bcd_tick_counter: illegal parameter set (DIV=%0d DIGITS=%0d STEP=%0d)", DIV, DIGITS, STEP);
  end

  logic [PW-1:0]         r_presc;
  logic [4*DIGITS-1:0]   r_bcd;
  logic                  r_tick;
  logic                  r_wrap;
  logic                  r_blink;

  logic                  w_tick_due;
  logic [DIGITS:0]       w_cy;
  logic [4*DIGITS-1:0]   w_step;
  logic [4*DIGITS-1:0]   w_load_sat;

  assign w_tick_due = i_en && (r_presc == LAST);
  assign w_cy[0]    = 1'b0;

  // Carry (up) or borrow (down) ripples digit to digit; STEP enters at digit 0.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [3:0] w_d;
    logic [3:0] w_add;
    logic [3:0] w_lv;
    logic [4:0] w_sum;
    logic [4:0] w_diff;
    logic       w_c_up;
    logic       w_b_dn;

    assign w_d    = r_bcd[4*gi +: 4];
    assign w_add  = (gi == 0) ? 4'(STEP) : 4'd0;
    assign w_sum  = {1'b0, w_d} + {1'b0, w_add} + {4'd0, w_cy[gi]};
    assign w_diff = {1'b0, w_d} + 5'd10 - {1'b0, w_add} - {4'd0, w_cy[gi]};
    assign w_c_up = (w_sum >= 5'd10);
    assign w_b_dn = (w_diff < 5'd10);

    assign w_cy[gi+1] = i_up ? w_c_up : w_b_dn;
    assign w_step[4*gi +: 4] = i_up ? (w_c_up ? 4'(w_sum - 5'd10) : w_sum[3:0])
                                    : (w_b_dn ? w_diff[3:0] : 4'(w_diff - 5'd10));

    assign w_lv = i_load_val[4*gi +: 4];
    assign w_load_sat[4*gi +: 4] = (w_lv > 4'd9) ? 4'd9 : w_lv;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc <= '0;
      r_bcd   <= '0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
      r_blink <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      if (i_clr) begin
        r_presc <= '0;
        r_bcd   <= '0;
      end else begin
        if (w_tick_due) begin
          r_presc <= '0;
          r_tick  <= 1'b1;
          r_blink <= ~r_blink;
        end else if (i_en) begin
          r_presc <= r_presc + PW'(1);
        end
        // A load on a tick edge consumes the tick without stepping the value.
        if (i_load) begin
          r_bcd <= w_load_sat;
        end else if (w_tick_due) begin
          r_bcd  <= w_step;
          r_wrap <= w_cy[DIGITS];
        end
      end
    end
  end

  assign o_bcd_out = r_bcd;
  assign o_tick    = r_tick;
  assign o_wrap    = r_wrap;
  assign o_blink   = r_blink;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Bench for bcd_tick_counter: two instances (STEP=1 and STEP=3) share stimulus;
// expected ticks are queued per scenario and checked as the DUT emits them.
module tb_bcd_tick_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;

  logic [7:0] bcd1, bcd3;
  logic       tick1, tick3, wrap1, wrap3, blink1, blink3;

  always #5 clk = ~clk;

  bcd_tick_counter #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(2), .STEP(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_up(up), .i_clr(clr), .i_load(load),
    .i_load_val(load_val), .o_bcd_out(bcd1), .o_tick(tick1), .o_wrap(wrap1), .o_blink(blink1)
  );

  bcd_tick_counter #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(2), .STEP(3)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_up(up), .i_clr(clr), .i_load(load),
    .i_load_val(load_val), .o_bcd_out(bcd3), .o_tick(tick3), .o_wrap(wrap3), .o_blink(blink3)
  );

  typedef struct {
    logic [7:0] bcd;
    logic       wrap;
    int         delay;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic exp_blink = 1'b0;

  task automatic sample(input int sel, output logic [7:0] b, output logic t,
                        output logic w, output logic bl);
    if (sel == 3) begin
      b = bcd3; t = tick3; w = wrap3; bl = blink3;
    end else begin
      b = bcd1; t = tick1; w = wrap1; bl = blink1;
    end
  endtask

  task automatic wait_tick(input int sel, input int budget, output int n);
    logic [7:0] b;
    logic t, w, bl;
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      sample(sel, b, t, w, bl);
      if (t === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Pops every queued expectation, waiting for each tick and checking it.
  task automatic run_sb(input int sel, input string name);
    exp_t e;
    int n;
    int pre;
    logic [7:0] b;
    logic t, w, bl;
    pre = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_tick(sel, e.delay + 5, n);
      checks++;
      if (n == 0) begin
        errors++;
        $display("FAIL %s timeout: no tick within %0d cycles, required delay %0d", name, e.delay + 5, e.delay);
        continue;
      end
      if (n + pre !== e.delay) begin
        errors++;
        $display("FAIL %s delay: got %0d required %0d", name, n + pre, e.delay);
      end
      exp_blink = ~exp_blink;
      sample(sel, b, t, w, bl);
      checks++;
      if (b !== e.bcd) begin
        errors++;
        $display("FAIL %s bcd: got %02h required %02h", name, b, e.bcd);
      end
      checks++;
      if (w !== e.wrap) begin
        errors++;
        $display("FAIL %s wrap: got %0b required %0b", name, w, e.wrap);
      end
      checks++;
      if (bl !== exp_blink) begin
        errors++;
        $display("FAIL %s blink: got %0b required %0b", name, bl, exp_blink);
      end
      $display("tick %s sel=%0d bcd=%02h wrap=%0b blink=%0b after %0d cycles", name, sel, b, w, bl, n + pre);
      @(negedge clk);
      sample(sel, b, t, w, bl);
      checks++;
      if (t !== 1'b0 || w !== 1'b0) begin
        errors++;
        $display("FAIL %s pulse width: tick=%0b wrap=%0b required 0 0", name, t, w);
      end
      pre = 1;
    end
  endtask

  // Clears prescaler and count with EN low, then loads a value.
  task automatic prep(input logic [7:0] v);
    en = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    load = 1'b1;
    load_val = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bcd1 !== 8'h00 || bcd3 !== 8'h00) begin
      errors++;
      $display("FAIL reset bcd: got %02h/%02h required 00", bcd1, bcd3);
    end
    checks++;
    if (tick1 !== 1'b0 || wrap1 !== 1'b0 || blink1 !== 1'b0) begin
      errors++;
      $display("FAIL reset flags: got tick=%0b wrap=%0b blink=%0b required 0", tick1, wrap1, blink1);
    end
    $display("reset bcd=%02h tick=%0b wrap=%0b blink=%0b", bcd1, tick1, wrap1, blink1);
    rst_n = 1'b1;
    exp_blink = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_count_up();
    up = 1'b1;
    en = 1'b1;
    sb.push_back('{8'h01, 1'b0, 10});
    sb.push_back('{8'h02, 1'b0, 10});
    sb.push_back('{8'h03, 1'b0, 10});
    run_sb(1, "count_up");
    en = 1'b0;
  endtask

  task automatic test_wrap_up();
    up = 1'b1;
    prep(8'h98);
    checks++;
    if (bcd3 !== 8'h98) begin
      errors++;
      $display("FAIL wrap_up load: got %02h required 98", bcd3);
    end
    en = 1'b1;
    sb.push_back('{8'h01, 1'b1, 10});
    run_sb(3, "wrap_up");
    en = 1'b0;
  endtask

  task automatic test_wrap_down();
    up = 1'b0;
    prep(8'h01);
    en = 1'b1;
    sb.push_back('{8'h98, 1'b1, 10});
    sb.push_back('{8'h95, 1'b0, 10});
    run_sb(3, "wrap_down");
    en = 1'b0;
    up = 1'b1;
  endtask

  task automatic test_load_sat();
    up = 1'b1;
    prep(8'h19);
    checks++;
    if (bcd1 !== 8'h19) begin
      errors++;
      $display("FAIL load_sat load: got %02h required 19", bcd1);
    end
    en = 1'b1;
    sb.push_back('{8'h20, 1'b0, 10});
    run_sb(1, "carry");
    en = 1'b0;
    prep(8'hAF);
    checks++;
    if (bcd1 !== 8'h99 || bcd3 !== 8'h99) begin
      errors++;
      $display("FAIL load_sat saturate: got %02h/%02h required 99", bcd1, bcd3);
    end
    $display("load AF -> bcd=%02h", bcd1);
  endtask

  task automatic test_en_hold();
    up = 1'b1;
    prep(8'h00);
    en = 1'b1;
    repeat (4) @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++;
      if (tick1 !== 1'b0 || bcd1 !== 8'h00) begin
        errors++;
        $display("FAIL en_hold cycle %0d: tick=%0b bcd=%02h required 0 00", i, tick1, bcd1);
      end
    end
    en = 1'b1;
    sb.push_back('{8'h01, 1'b0, 6});
    run_sb(1, "en_hold");
    en = 1'b0;
  endtask

  task automatic test_clr_load_tick();
    prep(8'h00);
    en = 1'b1;
    repeat (9) @(negedge clk);
    clr = 1'b1;
    load = 1'b1;
    load_val = 8'h55;
    @(negedge clk);
    clr = 1'b0;
    load = 1'b0;
    checks++;
    if (bcd1 !== 8'h00 || tick1 !== 1'b0 || wrap1 !== 1'b0 || blink1 !== exp_blink) begin
      errors++;
      $display("FAIL clr_load: bcd=%02h tick=%0b wrap=%0b blink=%0b required 00 0 0 %0b",
               bcd1, tick1, wrap1, blink1, exp_blink);
    end
    sb.push_back('{8'h01, 1'b0, 10});
    run_sb(1, "after_clr");
    en = 1'b0;
  endtask

  task automatic test_load_on_tick();
    prep(8'h00);
    en = 1'b1;
    repeat (9) @(negedge clk);
    load = 1'b1;
    load_val = 8'h42;
    @(negedge clk);
    load = 1'b0;
    exp_blink = ~exp_blink;
    checks++;
    if (bcd1 !== 8'h42 || tick1 !== 1'b1 || wrap1 !== 1'b0 || blink1 !== exp_blink) begin
      errors++;
      $display("FAIL load_tick: bcd=%02h tick=%0b wrap=%0b blink=%0b required 42 1 0 %0b",
               bcd1, tick1, wrap1, blink1, exp_blink);
    end
    sb.push_back('{8'h43, 1'b0, 10});
    run_sb(1, "after_load");
    en = 1'b0;
  endtask

  task automatic test_rst_mid();
    prep(8'h37);
    en = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bcd1 !== 8'h00 || bcd3 !== 8'h00 || tick1 !== 1'b0 || wrap1 !== 1'b0 || blink1 !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: bcd=%02h/%02h tick=%0b wrap=%0b blink=%0b required all 0",
               bcd1, bcd3, tick1, wrap1, blink1);
    end
    $display("async reset bcd=%02h blink=%0b", bcd1, blink1);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_blink = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap_up();
    test_wrap_down();
    test_load_sat();
    test_en_hold();
    test_clr_load_tick();
    test_load_on_tick();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
